// File: rtl/ren_iss_dispatch_if.sv
// Rename-to-issue dispatch bus: Rename handshake, IQ/LSQ push pairs, freeze/flush and occupancy.
// The master modport is the dispatch buffer; the slave modport is the surrounding pipeline.
interface ren_iss_dispatch_if #(
  parameter int RENISS_WIDTH = 151,
  parameter int ADDR_WIDTH   = 2
);
  logic                    FREEZE;
  logic                    FLUSH;
  logic                    REN_valid_IN;
  logic [RENISS_WIDTH-1:0] REN_data_IN;
  logic                    REN_stall_OUT;
  logic                    IQ_full_IN;
  logic                    LSQ_full_IN;
  logic                    IQ_pushReq_OUT;
  logic [RENISS_WIDTH-1:0] IQ_pushData_OUT;
  logic                    LSQ_pushReq_OUT;
  logic [RENISS_WIDTH-1:0] LSQ_pushData_OUT;
  logic [ADDR_WIDTH:0]     count_OUT;

  modport master (
    input  FREEZE, FLUSH, REN_valid_IN, REN_data_IN, IQ_full_IN, LSQ_full_IN,
    output REN_stall_OUT, IQ_pushReq_OUT, IQ_pushData_OUT,
           LSQ_pushReq_OUT, LSQ_pushData_OUT, count_OUT
  );

  modport slave (
    output FREEZE, FLUSH, REN_valid_IN, REN_data_IN, IQ_full_IN, LSQ_full_IN,
    input  REN_stall_OUT, IQ_pushReq_OUT, IQ_pushData_OUT,
           LSQ_pushReq_OUT, LSQ_pushData_OUT, count_OUT
  );
endinterface

// File: rtl/ren_iss_dispatch.sv
// In-order dispatch buffer between Rename and issue: small circular FIFO whose head
// is routed to the LSQ (loads/stores) or the IQ (everything else).
module ren_iss_dispatch #(
  parameter int RENISS_WIDTH = 151,
  parameter int ADDR_WIDTH   = 2,
  parameter int MEMREAD_BIT  = 39,
  parameter int MEMWRITE_BIT = 40
) (
  input  logic                CLK,
  input  logic                RESET,
  ren_iss_dispatch_if.master  bus
);
  localparam int                  DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [RENISS_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0]   head_q, head_d;
  logic [ADDR_WIDTH-1:0]   tail_q, tail_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;

  logic [RENISS_WIDTH-1:0] head_entry;
  logic                    empty, full, is_mem, accept, dispatch_ok, iq_req, lsq_req, pop;

  always_comb begin
    head_entry  = mem_q[head_q];
    is_mem      = head_entry[MEMREAD_BIT] | head_entry[MEMWRITE_BIT];
    empty       = (count_q == '0);
    full        = (count_q == CNT_FULL);
    // no full-bypass: a same-cycle pop never frees a slot for the incoming entry
    accept      = bus.REN_valid_IN & ~full & ~bus.FREEZE & ~bus.FLUSH;
    dispatch_ok = ~empty & ~bus.FREEZE & ~bus.FLUSH;
    iq_req      = dispatch_ok & ~is_mem & ~bus.IQ_full_IN;
    lsq_req     = dispatch_ok &  is_mem & ~bus.LSQ_full_IN;
    pop         = iq_req | lsq_req;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.FLUSH) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)    head_d = head_q + 1'b1;
      if (accept) tail_d = tail_q + 1'b1;
      if (accept && !pop)      count_d = count_q + 1'b1;
      else if (pop && !accept) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // storage contents are don't-care after reset, so it carries no reset
  always_ff @(posedge CLK) begin
    if (accept) mem_q[tail_q] <= bus.REN_data_IN;
  end

  // stall is gated by reset so a freeze held through reset does not leak out
  assign bus.REN_stall_OUT    = RESET & (full | bus.FREEZE);
  assign bus.IQ_pushReq_OUT   = iq_req;
  assign bus.LSQ_pushReq_OUT  = lsq_req;
  assign bus.IQ_pushData_OUT  = iq_req  ? head_entry : '0;
  assign bus.LSQ_pushData_OUT = lsq_req ? head_entry : '0;
  assign bus.count_OUT        = count_q;
endmodule

// File: tb/tb_ren_iss_dispatch.sv
// Self-checking bench for ren_iss_dispatch: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference of the dispatch buffer.
module tb_ren_iss_dispatch;
  localparam int W = 151;
  localparam int A = 2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [W-1:0] q[$];

  ren_iss_dispatch_if #(.RENISS_WIDTH(W), .ADDR_WIDTH(A)) bus ();

  ren_iss_dispatch #(.RENISS_WIDTH(W), .ADDR_WIDTH(A), .MEMREAD_BIT(39), .MEMWRITE_BIT(40)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkc(input string tag, input logic [A:0] obs, input logic [A:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // kind: 0 = ALU, 1 = load, 2 = store, 3 = load+store flags
  function automatic logic [W-1:0] mk(input int kind);
    logic [W-1:0] e;
    for (int i = 0; i < W; i++) e[i] = 1'($urandom_range(0, 1));
    e[39] = (kind == 1 || kind == 3);
    e[40] = (kind == 2 || kind == 3);
    return e;
  endfunction

  // One cycle: drive at negedge, check outputs against the reference, advance it at posedge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic iqf,
                      input logic lsqf, input logic frz, input logic fl);
    logic hm, e_full, e_iq, e_lsq;
    @(negedge clk);
    bus.REN_valid_IN = v;
    bus.REN_data_IN  = d;
    bus.IQ_full_IN   = iqf;
    bus.LSQ_full_IN  = lsqf;
    bus.FREEZE       = frz;
    bus.FLUSH        = fl;
    #1;
    e_full = (q.size() == 4);
    hm     = (q.size() > 0) ? (q[0][39] | q[0][40]) : 1'b0;
    e_iq   = (q.size() > 0) && !frz && !fl && !hm && !iqf;
    e_lsq  = (q.size() > 0) && !frz && !fl &&  hm && !lsqf;
    chk1("stall",    bus.REN_stall_OUT,   e_full | frz);
    chk1("iq_req",   bus.IQ_pushReq_OUT,  e_iq);
    chk1("lsq_req",  bus.LSQ_pushReq_OUT, e_lsq);
    chkd("iq_data",  bus.IQ_pushData_OUT,  e_iq  ? q[0] : '0);
    chkd("lsq_data", bus.LSQ_pushData_OUT, e_lsq ? q[0] : '0);
    chkc("count",    bus.count_OUT, (A+1)'(q.size()));
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (e_iq || e_lsq) void'(q.pop_front());
      if (v && !e_full && !frz) q.push_back(d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.REN_valid_IN = 1'b1;
    bus.REN_data_IN  = mk(0);
    bus.IQ_full_IN   = 1'b0;
    bus.LSQ_full_IN  = 1'b0;
    bus.FREEZE       = 1'b1;
    bus.FLUSH        = 1'b0;

    // reset: outputs idle even with freeze and valid asserted
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_stall",   bus.REN_stall_OUT,   1'b0);
    chk1("rst_iq_req",  bus.IQ_pushReq_OUT,  1'b0);
    chk1("rst_lsq_req", bus.LSQ_pushReq_OUT, 1'b0);
    chkd("rst_iq_data", bus.IQ_pushData_OUT, '0);
    chkd("rst_lsq_data", bus.LSQ_pushData_OUT, '0);
    chkc("rst_count",   bus.count_OUT, '0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.FREEZE = 1'b0;
    bus.REN_valid_IN = 1'b0;
    idle(1);

    // single ALU entry: IQ push exactly one cycle after accept
    step(1'b1, mk(0), 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // load then ALU with LSQ full for 3 cycles: ALU waits behind the load
    step(1'b1, mk(1), 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, mk(0), 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0,    1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0,    1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // fill with IQ full: 5th entry refused, then drain
    for (int i = 0; i < 5; i++) step(1'b1, mk(0), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(0), 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);

    // stream across the pointer wrap, alternating targets
    for (int i = 0; i < 10; i++) step(1'b1, mk((i % 2 == 0) ? 0 : 1 + (i % 3)), 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // freeze with 2 buffered and valid held
    step(1'b1, mk(0), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(2), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(0), 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, mk(0), 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // flush with 3 buffered and a concurrent valid entry
    for (int i = 0; i < 3; i++) step(1'b1, mk(i), 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, mk(0), 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), mk(int'($urandom_range(0, 3))),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 31) == 0));
    end
    idle(6);

    // reset mid-stream: push request must drop without waiting for a clock edge
    step(1'b1, mk(0), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(0), 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.REN_valid_IN = 1'b0;
    bus.IQ_full_IN   = 1'b0;
    #1;
    chk1("pre_rst_iq_req", bus.IQ_pushReq_OUT, 1'b1);
    #1;
    rst_n = 1'b0;
    bus.FREEZE = 1'b1;
    #1;
    chk1("mid_rst_iq_req",  bus.IQ_pushReq_OUT,  1'b0);
    chk1("mid_rst_lsq_req", bus.LSQ_pushReq_OUT, 1'b0);
    chk1("mid_rst_stall",   bus.REN_stall_OUT,   1'b0);
    chkd("mid_rst_iq_data", bus.IQ_pushData_OUT, '0);
    chkc("mid_rst_count",   bus.count_OUT, '0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.FREEZE = 1'b0;
    idle(2);
    step(1'b1, mk(1), 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
